pe_weight_loader: RTL
=====================

# pe_weight_loader

Sequencer that streams a layer's kernel and bias words into one `pe_incha_single` instance through its `weight_wr_data`/`weight_wr_addr`/`weight_wr_en` port.
- **Input side:** it accepts a flat valid/ready word stream and generates the 32-bit typed address (type, channel, position, reserved) for every word.
- **Completion:** it signals `done` when the layer's full parameter set has been written.
- **Input gating:** it holds the PE's `i_valid` low until every kernel and bias entry is loaded.
- **Placement:** it sits between the parameter DMA/stream source and the PE.

## Interface
Parameters:
- `IN_CHANNEL`, 2, PE input channels
- `OUT_CHANNEL`, 4, PE output channels; legal range 1..256
- `KERNEL_0`, 3, kernel dim 0
- `KERNEL_1`, 3, kernel dim 1
- `ADDR_TYPE_KERNEL`, 8'h00, address type field for kernel words
- `ADDR_TYPE_BIAS`, 8'h01, address type field for bias words
- Derived: `NK = KERNEL_0*KERNEL_1*IN_CHANNEL`, legal range 1..256. `NWORDS = OUT_CHANNEL*(NK+1)`.

Ports:
- `clk` in 1: the single clock
- `rst_n` in 1: reset, synchronous, active-low
- `start` in 1: single-cycle load request
- `s_data` in 16: parameter word
- `s_valid` in 1: `s_data` valid
- `s_ready` out 1: loader accepts the current word
- `weight_wr_data` out 16: to PE
- `weight_wr_addr` out 32: to PE; {type[31:24], channel[23:16], position[15:8], 8'h00}
- `weight_wr_en` out 1: to PE
- `busy` out 1: high in LOAD or FLUSH
- `done` out 1: sticky completion flag
- `loaded` out 1: PE parameters valid
- `pe_i_valid_in` in 1: upstream i_valid
- `pe_i_valid_out` out 1: `pe_i_valid_in & loaded`, combinational

## Operation
States:
- **IDLE:** `s_ready`=0.
  - `start`=1 → LOAD next edge.
  - On that same edge: channel counter `ch`=0, position counter `pos`=0, `done`=0, `loaded`=0.
- **LOAD:** `s_ready`=1. A beat is accepted when `s_valid & s_ready`.
  - **Kernel beat (`pos` < NK):**
    - Next edge writes `weight_wr_data` = {8'h00, s_data[7:0]}.
    - `weight_wr_addr` = {ADDR_TYPE_KERNEL, ch[7:0], pos[7:0], 8'h00}.
    - `pos` increments.
  - **Bias beat (`pos` == NK):**
    - Next edge writes `weight_wr_data` = `s_data` (full 16 bits).
    - `weight_wr_addr` = {ADDR_TYPE_BIAS, ch[7:0], 8'h00, 8'h00}.
    - `pos`←0 and `ch` increments.
  - **Last bias (`ch` == OUT_CHANNEL-1):** the accepting edge moves to FLUSH instead of incrementing `ch`.
  - **No beat in a cycle:** `weight_wr_en`=0 on the next cycle; counters hold.
- **FLUSH:** one cycle, `s_ready`=0. It covers the PE RAM write of the last word. The next edge → IDLE with `done`=1 and `loaded`=1.

Other rules:
- `start` in LOAD or FLUSH is ignored.
- `start` in IDLE while `done`=1 begins a reload: `loaded` drops immediately (next edge).
- **Reset** (`rst_n`=0 at an edge), including mid-load:
  - state=IDLE, `ch`=`pos`=0.
  - `weight_wr_en`=0, `weight_wr_data`=0, `weight_wr_addr`=0.
  - `done`=0, `loaded`=0.
  - No further writes are issued.
- Every output has reset value 0. `pe_i_valid_out` is 0 while `loaded`=0.

## Timing
- All outputs are registered, except `s_ready`, `busy` and `pe_i_valid_out`, which decode combinationally from state and registered `loaded`.
- Write latency: beat accepted at edge T → `weight_wr_en`=1 during cycle T..T+1, seen by the PE at edge T+1.
- Back-to-back beats give one write per cycle. Total minimum load time: 1 (start) + NWORDS + 1 (FLUSH) cycles.
- For the last beat accepted at edge T: FLUSH covers T..T+1, and `done`/`loaded` rise at edge T+2.
- `s_ready` is not a function of `s_valid`, so there is no combinational loop.

## Configuration
- Macro `PE_WEIGHT_LOADER_CKSUM_EN`.
- **Defined:** adds ports `exp_cksum` in 16, `cksum` out 16 and `cksum_err` out 1.
  - `cksum` is the modulo-2^16 sum of raw `s_data` over all accepted beats. It is cleared on `start` and reset.
  - At the FLUSH→IDLE edge, `cksum_err` = (`cksum` != `exp_cksum`).
  - `loaded` is set only if no mismatch. `done` is set regardless.
  - `cksum_err` clears on `start` and reset.
- **Undefined:** these ports and that logic are absent, and `loaded` is set unconditionally at the FLUSH→IDLE edge.

## Test plan
- **Defaults (NK=18, NWORDS=76), `start` then 76 back-to-back words `s_data` = 16'h0100+i:**
  - Exactly 76 writes.
  - Write 0: addr 32'h0000_0000, data 16'h0000.
  - Write 18: addr 32'h0100_0000, data 16'h0112.
  - Write 19: addr 32'h0001_0000.
  - Write 75: addr 32'h0103_0000.
  - `done`/`loaded` rise 2 cycles after the last beat.
- **`s_valid` toggling 1,0,1,0:** write count and addresses are identical to the back-to-back case; `weight_wr_en` never asserts in a cycle following a no-beat cycle.
- **`pe_i_valid_in`=1 throughout the load:** `pe_i_valid_out`=0 until `loaded` rises, then 1.
- **`rst_n`=0 for one cycle after 30 beats:**
  - All outputs are 0 the next cycle and no further writes occur.
  - A new `start` plus 76 words completes normally from ch=0, pos=0.
- **`start` pulsed during LOAD and during FLUSH:** ignored; completion timing is unchanged. `start` after `done` clears `done` and `loaded` next edge.
- **With `PE_WEIGHT_LOADER_CKSUM_EN`:**
  - `exp_cksum` = correct sum → `loaded`=1, `cksum_err`=0.
  - `exp_cksum` = sum+1 → `done`=1, `loaded`=0, `cksum_err`=1, and `pe_i_valid_out` stays 0.

Source files
------------

// File: rtl/pe_weight_loader.sv
// -----------------------------------------------------------------------------
// pe_weight_loader
//
// Streams one layer's kernel and bias words into a pe_incha_single instance.
// A flat valid/ready word stream is turned into typed PE weight writes:
// for every output channel, NK kernel words followed by one bias word.
// The PE's i_valid is gated off until the full parameter set is written.
//
// Optional feature (macro PE_WEIGHT_LOADER_CKSUM_EN): a modulo-2^16 sum of
// the raw accepted words is compared with exp_cksum when the load finishes.
// On a mismatch, cksum_err is raised and loaded stays low.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               single-cycle load request (honoured only in IDLE)
//   s_data/s_valid      parameter word stream in
//   s_ready             loader accepts the current word (LOAD state only)
//   weight_wr_data      PE weight write data (registered)
//   weight_wr_addr      PE weight address {type, channel, position, 8'h00}
//   weight_wr_en        PE weight write strobe (registered)
//   busy                high while in LOAD or FLUSH
//   done                sticky completion flag
//   loaded              PE parameters valid
//   pe_i_valid_in       upstream i_valid
//   pe_i_valid_out      pe_i_valid_in gated by loaded
//   exp_cksum, cksum, cksum_err   only with PE_WEIGHT_LOADER_CKSUM_EN
//
// Handshake: a word is transferred on a rising edge where s_valid & s_ready
// are both high. s_ready depends only on state, never on s_valid, so the
// source may wait for s_ready before raising s_valid or hold s_valid high.
//
// FSM state is held in state_q (type state_t) for checker binding.
// -----------------------------------------------------------------------------
module pe_weight_loader #(
  parameter int          IN_CHANNEL       = 2,
  parameter int          OUT_CHANNEL      = 4,
  parameter int          KERNEL_0         = 3,
  parameter int          KERNEL_1         = 3,
  parameter logic [7:0]  ADDR_TYPE_KERNEL = 8'h00,
  parameter logic [7:0]  ADDR_TYPE_BIAS   = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] weight_wr_data,
  output logic [31:0] weight_wr_addr,
  output logic        weight_wr_en,
  output logic        busy,
  output logic        done,
  output logic        loaded,
  input  logic        pe_i_valid_in,
`ifdef PE_WEIGHT_LOADER_CKSUM_EN
  output logic        pe_i_valid_out,
  input  logic [15:0] exp_cksum,
  output logic [15:0] cksum,
  output logic        cksum_err
`else
  output logic        pe_i_valid_out
`endif
);

  localparam int NK     = KERNEL_0 * KERNEL_1 * IN_CHANNEL;
  localparam int NWORDS = OUT_CHANNEL * (NK + 1);

  // pos must reach NK (up to 256), hence 9 bits; only pos[7:0] goes on the bus.
  localparam logic [8:0] POS_BIAS = 9'(NK);
  localparam logic [7:0] LAST_CH  = 8'(OUT_CHANNEL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  pos_q, pos_d;
  logic [7:0]  ch_q, ch_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic        done_q, done_d;
  logic        loaded_q, loaded_d;

  logic        beat;
  logic        is_bias;
  logic        is_last_ch;

`ifdef PE_WEIGHT_LOADER_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;
  logic        cksum_err_q, cksum_err_d;
`endif

  // Combinational decodes from state and registered loaded only.
  assign s_ready        = (state_q == S_LOAD);
  assign busy           = (state_q != S_IDLE);
  assign pe_i_valid_out = pe_i_valid_in & loaded_q;

  assign beat       = s_valid & s_ready;
  assign is_bias    = (pos_q == POS_BIAS);
  assign is_last_ch = (ch_q == LAST_CH);

  assign weight_wr_en   = wr_en_q;
  assign weight_wr_data = wr_data_q;
  assign weight_wr_addr = wr_addr_q;
  assign done           = done_q;
  assign loaded         = loaded_q;

`ifdef PE_WEIGHT_LOADER_CKSUM_EN
  assign cksum     = cksum_q;
  assign cksum_err = cksum_err_q;
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    ch_d      = ch_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    done_d    = done_q;
    loaded_d  = loaded_q;
`ifdef PE_WEIGHT_LOADER_CKSUM_EN
    cksum_d     = cksum_q;
    cksum_err_d = cksum_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Also the reload path: loaded drops on this edge so the PE
          // stops accepting data while its parameters are rewritten.
          state_d  = S_LOAD;
          pos_d    = '0;
          ch_d     = '0;
          done_d   = 1'b0;
          loaded_d = 1'b0;
`ifdef PE_WEIGHT_LOADER_CKSUM_EN
          cksum_d     = '0;
          cksum_err_d = 1'b0;
`endif
        end
      end

      S_LOAD: begin
        if (beat) begin
          wr_en_d = 1'b1;
`ifdef PE_WEIGHT_LOADER_CKSUM_EN
          cksum_d = cksum_q + s_data;
`endif
          if (!is_bias) begin
            // Kernel weights are 8-bit; upper byte of the PE word is zero.
            wr_data_d = {8'h00, s_data[7:0]};
            wr_addr_d = {ADDR_TYPE_KERNEL, ch_q, pos_q[7:0], 8'h00};
            pos_d     = pos_q + 9'd1;
          end else begin
            wr_data_d = s_data;
            wr_addr_d = {ADDR_TYPE_BIAS, ch_q, 8'h00, 8'h00};
            pos_d     = '0;
            if (is_last_ch) begin
              state_d = S_FLUSH;
            end else begin
              ch_d = ch_q + 8'd1;
            end
          end
        end
      end

      S_FLUSH: begin
        // One cycle so the last word's write lands in the PE before
        // loaded opens the i_valid gate.
        state_d = S_IDLE;
        done_d  = 1'b1;
`ifdef PE_WEIGHT_LOADER_CKSUM_EN
        cksum_err_d = (cksum_q != exp_cksum);
        loaded_d    = (cksum_q == exp_cksum);
`else
        loaded_d = 1'b1;
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      ch_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      loaded_q  <= 1'b0;
`ifdef PE_WEIGHT_LOADER_CKSUM_EN
      cksum_q     <= '0;
      cksum_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      ch_q      <= ch_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      done_q    <= done_d;
      loaded_q  <= loaded_d;
`ifdef PE_WEIGHT_LOADER_CKSUM_EN
      cksum_q     <= cksum_d;
      cksum_err_q <= cksum_err_d;
`endif
    end
  end

endmodule
